// File: rtl/xfcp_arb_4x1.sv
// ---------------------------------------------------------------------------
// xfcp_arb_4x1
//
// Purpose:
//   Merges four downstream XFCP response streams into one upstream stream.
//   Arbitration is per whole packet, so a packet is never interleaved with
//   another one. Each arbitration decision costs one cycle in IDLE. After that
//   the granted port is forwarded combinationally until a beat with tlast=1
//   is accepted.
//
// Parameters:
//   ROUND_ROBIN : 1 = round-robin between packets. The search starts at
//                 (last_grant+1) mod 4.
//                 0 = fixed priority. Port 0 has the highest priority.
//
// Compile-time option:
//   XFCP_ARB_PORT_TAG_EN : when defined, a single tag beat is emitted before
//                          each forwarded packet. The tag beat carries
//                          tdata = {6'b0, grant}, tlast = 0 and tuser = 0.
//                          When undefined, the output bytes are exactly the
//                          input packets.
//
// Ports:
//   clk, rst                      : clock and synchronous active-high reset
//   down_xfcp_N_in_*  (N = 0..3)  : AXI-stream style ingress.
//                                   tdata[7:0], tvalid, tready (out), tlast,
//                                   tuser (error flag).
//   up_xfcp_out_*                 : merged egress.
//                                   tdata[7:0], tvalid, tready (in), tlast,
//                                   tuser.
// ---------------------------------------------------------------------------
module xfcp_arb_4x1 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk,
    input  logic       rst,

    input  logic [7:0] down_xfcp_0_in_tdata,
    input  logic       down_xfcp_0_in_tvalid,
    output logic       down_xfcp_0_in_tready,
    input  logic       down_xfcp_0_in_tlast,
    input  logic       down_xfcp_0_in_tuser,

    input  logic [7:0] down_xfcp_1_in_tdata,
    input  logic       down_xfcp_1_in_tvalid,
    output logic       down_xfcp_1_in_tready,
    input  logic       down_xfcp_1_in_tlast,
    input  logic       down_xfcp_1_in_tuser,

    input  logic [7:0] down_xfcp_2_in_tdata,
    input  logic       down_xfcp_2_in_tvalid,
    output logic       down_xfcp_2_in_tready,
    input  logic       down_xfcp_2_in_tlast,
    input  logic       down_xfcp_2_in_tuser,

    input  logic [7:0] down_xfcp_3_in_tdata,
    input  logic       down_xfcp_3_in_tvalid,
    output logic       down_xfcp_3_in_tready,
    input  logic       down_xfcp_3_in_tlast,
    input  logic       down_xfcp_3_in_tuser,

    output logic [7:0] up_xfcp_out_tdata,
    output logic       up_xfcp_out_tvalid,
    input  logic       up_xfcp_out_tready,
    output logic       up_xfcp_out_tlast,
    output logic       up_xfcp_out_tuser
);

    localparam int NUM_PORTS = 4;

    // The ports are gathered into indexable arrays, so the arbiter and the
    // mux can address them by grant index.
    logic [7:0]           in_tdata [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_tvalid;
    logic [NUM_PORTS-1:0] in_tlast;
    logic [NUM_PORTS-1:0] in_tuser;
    logic [NUM_PORTS-1:0] in_tready;

    assign in_tdata[0] = down_xfcp_0_in_tdata;
    assign in_tdata[1] = down_xfcp_1_in_tdata;
    assign in_tdata[2] = down_xfcp_2_in_tdata;
    assign in_tdata[3] = down_xfcp_3_in_tdata;

    assign in_tvalid = {down_xfcp_3_in_tvalid, down_xfcp_2_in_tvalid,
                        down_xfcp_1_in_tvalid, down_xfcp_0_in_tvalid};
    assign in_tlast  = {down_xfcp_3_in_tlast,  down_xfcp_2_in_tlast,
                        down_xfcp_1_in_tlast,  down_xfcp_0_in_tlast};
    assign in_tuser  = {down_xfcp_3_in_tuser,  down_xfcp_2_in_tuser,
                        down_xfcp_1_in_tuser,  down_xfcp_0_in_tuser};

    assign down_xfcp_0_in_tready = in_tready[0];
    assign down_xfcp_1_in_tready = in_tready[1];
    assign down_xfcp_2_in_tready = in_tready[2];
    assign down_xfcp_3_in_tready = in_tready[3];

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
`ifdef XFCP_ARB_PORT_TAG_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_PASS = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd2
    } state_t;
`endif

    state_t     state_reg,       state_next;
    logic [1:0] grant_reg,       grant_next;
    logic       grant_valid_reg, grant_valid_next;
    logic [1:0] last_grant_reg,  last_grant_next;

    // -----------------------------------------------------------------------
    // Arbiter: choose the winning requester among the valid ports.
    // -----------------------------------------------------------------------
    logic       arb_found;
    logic [1:0] arb_index;
    logic [1:0] arb_probe;

    always_comb begin
        arb_found = 1'b0;
        arb_index = 2'd0;
        arb_probe = 2'd0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // The 2-bit add wraps modulo 4. This makes the round-robin search
            // begin just after the most recently served port.
            if (ROUND_ROBIN != 0) begin
                arb_probe = last_grant_reg + 2'(k + 1);
            end else begin
                arb_probe = 2'(k);
            end
            if (!arb_found && in_tvalid[arb_probe]) begin
                arb_found = 1'b1;
                arb_index = arb_probe;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= 2'd0;
            grant_valid_reg <= 1'b0;
            last_grant_reg  <= 2'd3;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            grant_valid_reg <= grant_valid_next;
            last_grant_reg  <= last_grant_next;
        end
    end

    // A packet ends on an accepted beat of the granted port that has tlast set.
    logic pass_last_accept;
    assign pass_last_accept = in_tvalid[grant_reg] && up_xfcp_out_tready &&
                              in_tlast[grant_reg];

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        grant_valid_next = grant_valid_reg;
        last_grant_next  = last_grant_reg;

        case (state_reg)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_next       = arb_index;
                    grant_valid_next = 1'b1;
`ifdef XFCP_ARB_PORT_TAG_EN
                    state_next       = ST_TAG;
`else
                    state_next       = ST_PASS;
`endif
                end
            end
`ifdef XFCP_ARB_PORT_TAG_EN
            ST_TAG: begin
                // The tag beat must be accepted upstream before payload flows.
                if (up_xfcp_out_tready) begin
                    state_next = ST_PASS;
                end
            end
`endif
            ST_PASS: begin
                // If tvalid drops mid-packet, the grant is simply held.
                // Only the final accepted beat releases the grant.
                if (grant_valid_reg && pass_last_accept) begin
                    state_next       = ST_IDLE;
                    grant_valid_next = 1'b0;
                    last_grant_next  = grant_reg;
                end
            end
            default: begin
                state_next       = ST_IDLE;
                grant_valid_next = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output mux. The outputs are forced low while rst is high, so they are
    // already quiet during the reset cycle itself and not only after it.
    // -----------------------------------------------------------------------
    logic pass_active;
    assign pass_active = !rst && (state_reg == ST_PASS) && grant_valid_reg;

    always_comb begin
        up_xfcp_out_tdata  = 8'd0;
        up_xfcp_out_tvalid = 1'b0;
        up_xfcp_out_tlast  = 1'b0;
        up_xfcp_out_tuser  = 1'b0;
        if (pass_active) begin
            up_xfcp_out_tdata  = in_tdata[grant_reg];
            up_xfcp_out_tvalid = in_tvalid[grant_reg];
            up_xfcp_out_tlast  = in_tlast[grant_reg];
            up_xfcp_out_tuser  = in_tuser[grant_reg];
        end
`ifdef XFCP_ARB_PORT_TAG_EN
        else if (!rst && state_reg == ST_TAG) begin
            up_xfcp_out_tdata  = {6'b0, grant_reg};
            up_xfcp_out_tvalid = 1'b1;
        end
`endif
    end

    // The ready signal goes back only to the granted port.
    // All other ports are stalled until a later IDLE cycle considers them.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
            assign in_tready[gi] = pass_active && (grant_reg == 2'(gi)) &&
                                   up_xfcp_out_tready;
        end
    endgenerate

endmodule

// File: tb/tb_xfcp_arb_4x1.sv
// ---------------------------------------------------------------------------
// tb_xfcp_arb_4x1
//
// Directed testbench for xfcp_arb_4x1.
//   - Per-port source queues feed the ingress ports. A beat is popped once the
//     port's tvalid and tready are both seen high.
//   - Every expected upstream beat ({tuser, tlast, tdata}) is pushed to a
//     scoreboard queue when its stimulus is queued. The scoreboard is popped
//     whenever an upstream transfer is seen.
//   - A second instance with ROUND_ROBIN=0 exercises fixed priority.
// Honours XFCP_ARB_PORT_TAG_EN to expect the tag beat in front of each packet.
// ---------------------------------------------------------------------------
module tb_xfcp_arb_4x1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] in_tdata [4];
    logic [3:0] in_tvalid;
    logic [3:0] in_tlast;
    logic [3:0] in_tuser;
    logic [3:0] in_tready;
    logic [7:0] up_tdata;
    logic       up_tvalid;
    logic       up_tready;
    logic       up_tlast;
    logic       up_tuser;

    logic [3:0] hold;
    logic       rdy_toggle;

    logic [9:0] src_q [4][$];
    logic [9:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    xfcp_arb_4x1 #(.ROUND_ROBIN(1)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .down_xfcp_0_in_tdata  (in_tdata[0]),
        .down_xfcp_0_in_tvalid (in_tvalid[0]),
        .down_xfcp_0_in_tready (in_tready[0]),
        .down_xfcp_0_in_tlast  (in_tlast[0]),
        .down_xfcp_0_in_tuser  (in_tuser[0]),
        .down_xfcp_1_in_tdata  (in_tdata[1]),
        .down_xfcp_1_in_tvalid (in_tvalid[1]),
        .down_xfcp_1_in_tready (in_tready[1]),
        .down_xfcp_1_in_tlast  (in_tlast[1]),
        .down_xfcp_1_in_tuser  (in_tuser[1]),
        .down_xfcp_2_in_tdata  (in_tdata[2]),
        .down_xfcp_2_in_tvalid (in_tvalid[2]),
        .down_xfcp_2_in_tready (in_tready[2]),
        .down_xfcp_2_in_tlast  (in_tlast[2]),
        .down_xfcp_2_in_tuser  (in_tuser[2]),
        .down_xfcp_3_in_tdata  (in_tdata[3]),
        .down_xfcp_3_in_tvalid (in_tvalid[3]),
        .down_xfcp_3_in_tready (in_tready[3]),
        .down_xfcp_3_in_tlast  (in_tlast[3]),
        .down_xfcp_3_in_tuser  (in_tuser[3]),
        .up_xfcp_out_tdata     (up_tdata),
        .up_xfcp_out_tvalid    (up_tvalid),
        .up_xfcp_out_tready    (up_tready),
        .up_xfcp_out_tlast     (up_tlast),
        .up_xfcp_out_tuser     (up_tuser)
    );

    // Fixed-priority instance: ports 1 and 3 request continuously.
    logic       fp_valid1 = 1'b0;
    logic       fp_valid3 = 1'b0;
    logic       fp_ready0;
    logic       fp_ready1;
    logic       fp_ready2;
    logic       fp_ready3;
    logic [7:0] fp_up_data;
    logic       fp_up_valid;
    logic       fp_up_last;
    logic       fp_up_user;
    logic       fp_up_ready = 1'b1;
    logic [7:0] zero8       = 8'd0;
    logic       zero1       = 1'b0;
    logic       one1        = 1'b1;
    logic [7:0] fp_data1    = 8'h51;
    logic [7:0] fp_data3    = 8'h53;

    xfcp_arb_4x1 #(.ROUND_ROBIN(0)) dut_fp (
        .clk                   (clk),
        .rst                   (rst),
        .down_xfcp_0_in_tdata  (zero8),
        .down_xfcp_0_in_tvalid (zero1),
        .down_xfcp_0_in_tready (fp_ready0),
        .down_xfcp_0_in_tlast  (zero1),
        .down_xfcp_0_in_tuser  (zero1),
        .down_xfcp_1_in_tdata  (fp_data1),
        .down_xfcp_1_in_tvalid (fp_valid1),
        .down_xfcp_1_in_tready (fp_ready1),
        .down_xfcp_1_in_tlast  (one1),
        .down_xfcp_1_in_tuser  (zero1),
        .down_xfcp_2_in_tdata  (zero8),
        .down_xfcp_2_in_tvalid (zero1),
        .down_xfcp_2_in_tready (fp_ready2),
        .down_xfcp_2_in_tlast  (zero1),
        .down_xfcp_2_in_tuser  (zero1),
        .down_xfcp_3_in_tdata  (fp_data3),
        .down_xfcp_3_in_tvalid (fp_valid3),
        .down_xfcp_3_in_tready (fp_ready3),
        .down_xfcp_3_in_tlast  (one1),
        .down_xfcp_3_in_tuser  (zero1),
        .up_xfcp_out_tdata     (fp_up_data),
        .up_xfcp_out_tvalid    (fp_up_valid),
        .up_xfcp_out_tready    (fp_up_ready),
        .up_xfcp_out_tlast     (fp_up_last),
        .up_xfcp_out_tuser     (fp_up_user)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {18'd0, up_tvalid, up_tlast, up_tuser, up_tdata, in_tready}, 32'd0);
    endtask

    task automatic push_tag(input int port);
`ifdef XFCP_ARB_PORT_TAG_EN
        exp_q.push_back({2'b00, 6'b0, 2'(port)});
`else
        if (port < 0) exp_q.push_back(10'd0);
`endif
    endtask

    task automatic send(input int port, input int len, input logic [7:0] base, input logic user);
        logic [9:0] e;
        push_tag(port);
        for (int b = 0; b < len; b++) begin
            e = {user, (b == len - 1), 8'(base + 8'(b))};
            src_q[port].push_back(e);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_src(input int port, input int n);
        for (int c = 0; c < 200; c++) begin
            if (src_q[port].size() == n) break;
            tick();
        end
        chk("wait_src", src_q[port].size(), n);
    endtask

    // Ingress driver: presents the head of each source queue.
    initial begin
        logic [3:0] acc;
        for (int i = 0; i < 4; i++) in_tdata[i] = 8'd0;
        in_tvalid  = 4'd0;
        in_tlast   = 4'd0;
        in_tuser   = 4'd0;
        up_tready  = 1'b1;
        hold       = 4'd0;
        rdy_toggle = 1'b0;
        forever begin
            @(negedge clk);
            acc = in_tvalid & in_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0 && !hold[i]) begin
                    {in_tuser[i], in_tlast[i], in_tdata[i]} = src_q[i][0];
                    in_tvalid[i] = 1'b1;
                end else begin
                    in_tdata[i]  = 8'd0;
                    in_tlast[i]  = 1'b0;
                    in_tuser[i]  = 1'b0;
                    in_tvalid[i] = 1'b0;
                end
            end
            up_tready = rdy_toggle ? !up_tready : 1'b1;
        end
    end

    // Upstream monitor / scoreboard.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst && up_tvalid && up_tready) begin
                chk("beat_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat", {22'd0, up_tuser, up_tlast, up_tdata}, {22'd0, e});
                    $display("beat user=%0d last=%0d data=%h", up_tuser, up_tlast, up_tdata);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        // Outputs during reset and right after it.
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_outputs");
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle_outputs");

        // A 4-byte packet arrives on port 2.
        send(2, 4, 8'h01, 1'b0);
        wait_empty("pkt_port2");

        // All four ports request together twice; round-robin gives 0,1,2,3.
        do_reset();
        for (int p = 0; p < 4; p++) send(p, 2, 8'(8'h10 + 8'(16 * p)), 1'b0);
        wait_empty("rr_round1");
        for (int p = 0; p < 4; p++) send(p, 2, 8'(8'h18 + 8'(16 * p)), 1'b0);
        wait_empty("rr_round2");

        // Port 2 drops tvalid mid-packet while port 0 waits.
        do_reset();
        send(2, 4, 8'h40, 1'b0);
        wait_src(2, 2);
        hold[2] = 1'b1;
        send(0, 2, 8'h50, 1'b0);
        tick();
        repeat (4) begin
            @(negedge clk);
            chk("stall_up_valid", {31'd0, up_tvalid}, 0);
            chk("stall_ready0", {31'd0, in_tready[0]}, 0);
        end
        hold[2] = 1'b0;
        wait_empty("stall_resume");

        // Upstream tready toggles during a 6-byte packet from port 0.
        do_reset();
        rdy_toggle = 1'b1;
        send(0, 6, 8'h60, 1'b0);
        send(1, 2, 8'h70, 1'b0);
        for (int c = 0; c < 200 && src_q[0].size() > 0; c++) begin
            @(negedge clk);
            chk("p1_ready_low", {31'd0, in_tready[1]}, 0);
        end
        wait_empty("toggle_ready");
        rdy_toggle = 1'b0;

        // Reset is asserted on the 3rd beat of a port-1 packet.
        do_reset();
        send(1, 5, 8'h80, 1'b0);
        wait_src(1, 3);
        rst = 1'b1;
        exp_q.delete();
        send(0, 2, 8'h90, 1'b0);
        push_tag(1);
        for (int i = 0; i < src_q[1].size(); i++) exp_q.push_back(src_q[1][i]);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero("after_mid_reset");
        wait_empty("mid_reset_recover");

        // Single-beat packet on port 3 with tuser set.
        send(3, 1, 8'hAA, 1'b1);
        wait_empty("single_beat");
        tick();
        tick();
        @(negedge clk);
        check_zero("grant_released");

        // Fixed priority: port 1 always wins over port 3.
        tick();
        fp_valid1 = 1'b1;
        fp_valid3 = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            chk("fp_ready3", {31'd0, fp_ready3}, 0);
            if (fp_up_valid) chk("fp_not_port3", {31'd0, (fp_up_data == 8'h53)}, 0);
            if (fp_up_valid && fp_ready1) cnt++;
        end
        chk("fp_port1_served", {31'd0, (cnt >= 10)}, 1);
        fp_valid1 = 1'b0;
        fp_valid3 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
